pd_tx_arbiter: RTL
==================

// Module: pd_tx_arbiter
// PURPOSE
//  Schedules the shared PHY transmitter between two requesters: rx (GoodCRC replies) and TCPM (TX buffer).
//  Sequences TCPM messages through transmit, wait-for-partner-GoodCRC, retry and report.
//  Sits between the rx block, the TCPM TX-buffer registers and the PHY TX datapath.
//  GoodCRC always has priority; a message in flight is never pre-empted.
// PARAMETERS
//  TIMER_W      8    width of timeout/retry timer counter
//  TX_TIMEOUT   100  max cycles from phy_tx_start to phy_tx_done before failure
//  CRC_TIMEOUT  60   max cycles after phy_tx_done to see phy_rx_goodcrc (CRCReceiveTimer)
//  N_RETRY      3    retransmissions after first attempt (nRetryCount), 0..7
// PORTS
//  clk                   in  1  system clock, all logic rising-edge
//  hard_reset            in  1  synchronous, active-low reset
//  goodcrc_req           in  1  1-cycle pulse from rx: send GoodCRC
//  goodcrc_hdr_0         in  8  GoodCRC header byte 0, valid with goodcrc_req
//  goodcrc_hdr_1         in  8  GoodCRC header byte 1, valid with goodcrc_req
//  tcpm_tx_req           in  1  1-cycle pulse: transmit TX buffer
//  tcpm_hdr_0            in  8  TX_BUF_HEADER_BYTE_0, valid with tcpm_tx_req
//  tcpm_hdr_1            in  8  TX_BUF_HEADER_BYTE_1, valid with tcpm_tx_req
//  phy_rx_busy           in  1  PHY receiving; no transmit may start while 1
//  phy_tx_done           in  1  1-cycle pulse: PHY finished current frame
//  phy_rx_goodcrc        in  1  1-cycle pulse: partner GoodCRC received
//  phy_tx_start          out 1  1-cycle pulse: PHY begins frame
//  phy_tx_hdr_0          out 8  header byte 0 to PHY, stable from start to done
//  phy_tx_hdr_1          out 8  header byte 1 to PHY, stable from start to done
//  goodcrc_tx_complete   out 1  1-cycle pulse: our GoodCRC sent
//  tcpm_tx_success       out 1  1-cycle pulse: message acknowledged
//  tcpm_tx_failed        out 1  1-cycle pulse: retries exhausted or PHY timeout
//  tx_busy               out 1  1 whenever state != IDLE or a request is pending
// BEHAVIOUR
//  Reset (hard_reset==0 at edge): state=IDLE, pending flags, timer, retry_cnt, all outputs = 0; overrides everything, incl. mid-frame.
//  Requests: each req pulse latches its header bytes + pending flag on the same edge; flag cleared on the edge phy_tx_start is issued for it.
//   Second req of same kind while pending: headers overwritten, one transmission only.
//   tcpm_tx_req while a TCPM message is in flight (past IDLE): ignored, no status pulse.
//  States:
//   IDLE: if phy_rx_busy=1 stay. Else gcrc_pend -> G_START; else msg_pend -> M_START (retry_cnt=0).
//    Request pulsed in cycle n with IDLE, rx idle -> phy_tx_start in cycle n+1 (state START).
//   G_START: phy_tx_start=1, hdr=gcrc bytes, timer=0 -> G_WAIT.
//   G_WAIT: phy_tx_done -> goodcrc_tx_complete=1 next cycle, -> IDLE. timer==TX_TIMEOUT -> IDLE, no pulse.
//   M_START: phy_tx_start=1, hdr=tcpm bytes, timer=0 -> M_WAIT.
//   M_WAIT: phy_tx_done -> timer=0, CRC_WAIT. timer==TX_TIMEOUT -> tcpm_tx_failed, IDLE.
//   CRC_WAIT: phy_rx_goodcrc -> tcpm_tx_success, IDLE.
//    timer==CRC_TIMEOUT: retry_cnt<N_RETRY -> retry_cnt+1, M_START (waits for !phy_rx_busy); else tcpm_tx_failed, IDLE.
//  Timer: increments every cycle in *_WAIT, saturates at 2^TIMER_W-1; TX/CRC_TIMEOUT < 2^TIMER_W (elab check).
//  Simultaneous: done and timeout same cycle -> done wins. goodcrc and timeout same cycle -> goodcrc wins.
//   goodcrc_req and tcpm_tx_req same cycle -> both latched, GoodCRC sent first.
//   goodcrc_req during M_WAIT/CRC_WAIT -> pending, served on next IDLE; in-flight message unaffected.
//  Status pulses registered, exactly one cycle, mutually exclusive; exactly one per accepted TCPM request.
// TESTING
//  T1 reset: hard_reset=0 mid-M_WAIT -> next cycle state IDLE, all outputs 0, pending cleared.
//  T2 goodcrc_req hdr 0x41/0x01 at cycle 10 -> phy_tx_start @11, hdrs 0x41/0x01; done @20 -> goodcrc_tx_complete @21.
//  T3 tcpm_tx_req hdr 0xA1/0x11; done after 30 cycles; phy_rx_goodcrc 5 later -> tcpm_tx_success, no retry.
//  T4 no partner GoodCRC -> 4 phy_tx_start pulses spaced by CRC_TIMEOUT, then tcpm_tx_failed once.
//  T5 goodcrc_req+tcpm_tx_req same cycle -> GoodCRC frame first, TCPM frame after its done; phy_rx_busy=1 delays both starts.
//  T6 phy_tx_done never arrives for TCPM frame -> tcpm_tx_failed exactly TX_TIMEOUT+1 cycles after start, state IDLE.

Source files
------------

// File: rtl/pd_tx_arbiter_if.sv
// Bus between the TX arbiter and its neighbours: rx block, TCPM TX buffer and PHY TX datapath.
// Handshake semantics: every *_req, *_done, *_goodcrc, *_start and status signal is a
// single-cycle pulse sampled on the rising clock edge. Header bytes are valid in the cycle
// their request pulses. phy_tx_hdr_* are held stable from phy_tx_start until phy_tx_done.
// phy_rx_busy and tx_busy are levels.
interface pd_tx_arbiter_if;
    logic       goodcrc_req;
    logic [7:0] goodcrc_hdr_0;
    logic [7:0] goodcrc_hdr_1;
    logic       tcpm_tx_req;
    logic [7:0] tcpm_hdr_0;
    logic [7:0] tcpm_hdr_1;
    logic       phy_rx_busy;
    logic       phy_tx_done;
    logic       phy_rx_goodcrc;
    logic       phy_tx_start;
    logic [7:0] phy_tx_hdr_0;
    logic [7:0] phy_tx_hdr_1;
    logic       goodcrc_tx_complete;
    logic       tcpm_tx_success;
    logic       tcpm_tx_failed;
    logic       tx_busy;

    modport slave (
        input  goodcrc_req, goodcrc_hdr_0, goodcrc_hdr_1,
        input  tcpm_tx_req, tcpm_hdr_0, tcpm_hdr_1,
        input  phy_rx_busy, phy_tx_done, phy_rx_goodcrc,
        output phy_tx_start, phy_tx_hdr_0, phy_tx_hdr_1,
        output goodcrc_tx_complete, tcpm_tx_success, tcpm_tx_failed, tx_busy
    );

    modport master (
        output goodcrc_req, goodcrc_hdr_0, goodcrc_hdr_1,
        output tcpm_tx_req, tcpm_hdr_0, tcpm_hdr_1,
        output phy_rx_busy, phy_tx_done, phy_rx_goodcrc,
        input  phy_tx_start, phy_tx_hdr_0, phy_tx_hdr_1,
        input  goodcrc_tx_complete, tcpm_tx_success, tcpm_tx_failed, tx_busy
    );
endinterface

// File: rtl/pd_tx_arbiter.sv
// Shared PHY transmitter scheduler: GoodCRC replies from rx take priority over TCPM
// messages; a TCPM message is sequenced through transmit, partner-GoodCRC wait, retry
// and a single success/failed report. A frame in flight is never pre-empted.
// The timer counts cycles since phy_tx_start (0 in the start cycle) while waiting for
// phy_tx_done, and cycles since entering CRC_WAIT while waiting for partner GoodCRC.
module pd_tx_arbiter #(
    parameter int TIMER_W     = 8,
    parameter int TX_TIMEOUT  = 100,
    parameter int CRC_TIMEOUT = 60,
    parameter int N_RETRY     = 3
) (
    input  logic           clk,
    input  logic           hard_reset,
    pd_tx_arbiter_if.slave bus,
    output logic [2:0]     fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        G_START  = 3'd1,
        G_WAIT   = 3'd2,
        M_START  = 3'd3,
        M_WAIT   = 3'd4,
        CRC_WAIT = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0] TX_TO     = TIMER_W'(TX_TIMEOUT);
    localparam logic [TIMER_W-1:0] CRC_TO    = TIMER_W'(CRC_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
    localparam logic [2:0]         RETRY_MAX = 3'(N_RETRY);

    if (TX_TIMEOUT >= (1 << TIMER_W) || CRC_TIMEOUT >= (1 << TIMER_W)) begin : g_bad_timeout
        $error("pd_tx_arbiter: TX_TIMEOUT and CRC_TIMEOUT must be below 2**TIMER_W");
    end
    if (N_RETRY < 0 || N_RETRY > 7) begin : g_bad_retry
        $error("pd_tx_arbiter: N_RETRY must be in 0..7");
    end

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt, timer_inc;
    logic [2:0]         retry_cnt, retry_nxt;
    logic               gcrc_pend, msg_pend;
    logic [7:0]         gcrc_h0, gcrc_h1, msg_h0, msg_h1;
    logic [7:0]         tx_h0, tx_h1;
    logic               gdone_q, succ_q, fail_q;
    logic               gdone_nxt, succ_nxt, fail_nxt;
    logic               tx_start, take_g, take_m;
    logic               msg_in_flight, msg_accept, gcrc_any, msg_any;

    // Request acceptance: TCPM requests are dropped while its own message is in flight.
    always_comb begin
        msg_in_flight = (state == M_START) || (state == M_WAIT) || (state == CRC_WAIT);
        msg_accept    = bus.tcpm_tx_req && !msg_in_flight;
        gcrc_any      = gcrc_pend || bus.goodcrc_req;
        msg_any       = msg_pend || msg_accept;
        timer_inc     = (timer == TIMER_MAX) ? timer : timer + 1'b1;
    end

    // Next-state, timer, retry counter and status pulse decode.
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        retry_nxt = retry_cnt;
        take_g    = 1'b0;
        take_m    = 1'b0;
        tx_start  = 1'b0;
        gdone_nxt = 1'b0;
        succ_nxt  = 1'b0;
        fail_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.phy_rx_busy) begin
                    if (gcrc_any) begin
                        state_nxt = G_START;
                        take_g    = 1'b1;
                    end else if (msg_any) begin
                        state_nxt = M_START;
                        take_m    = 1'b1;
                        retry_nxt = 3'd0;
                    end
                end
            end
            G_START: begin
                if (!bus.phy_rx_busy) begin
                    tx_start  = 1'b1;
                    timer_nxt = TIMER_W'(1);
                    state_nxt = G_WAIT;
                end
            end
            G_WAIT: begin
                if (bus.phy_tx_done) begin
                    gdone_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TX_TO) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            M_START: begin
                if (!bus.phy_rx_busy) begin
                    tx_start  = 1'b1;
                    timer_nxt = TIMER_W'(1);
                    state_nxt = M_WAIT;
                end
            end
            M_WAIT: begin
                if (bus.phy_tx_done) begin
                    state_nxt = CRC_WAIT;
                end else if (timer == TX_TO) begin
                    fail_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            CRC_WAIT: begin
                if (bus.phy_rx_goodcrc) begin
                    succ_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == CRC_TO) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt = retry_cnt + 3'd1;
                        state_nxt = M_START;
                    end else begin
                        fail_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pending requests, latched headers, PHY header hold and status pulse registers.
    always_ff @(posedge clk) begin
        if (!hard_reset) begin
            state     <= IDLE;
            timer     <= '0;
            retry_cnt <= 3'd0;
            gcrc_pend <= 1'b0;
            msg_pend  <= 1'b0;
            gcrc_h0   <= 8'd0;
            gcrc_h1   <= 8'd0;
            msg_h0    <= 8'd0;
            msg_h1    <= 8'd0;
            tx_h0     <= 8'd0;
            tx_h1     <= 8'd0;
            gdone_q   <= 1'b0;
            succ_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            retry_cnt <= retry_nxt;
            gcrc_pend <= take_g ? 1'b0 : gcrc_any;
            msg_pend  <= take_m ? 1'b0 : msg_any;
            if (bus.goodcrc_req) begin
                gcrc_h0 <= bus.goodcrc_hdr_0;
                gcrc_h1 <= bus.goodcrc_hdr_1;
            end
            if (msg_accept) begin
                msg_h0 <= bus.tcpm_hdr_0;
                msg_h1 <= bus.tcpm_hdr_1;
            end
            // A request arriving on the same edge it is taken supplies the freshest bytes.
            if (take_g) begin
                tx_h0 <= bus.goodcrc_req ? bus.goodcrc_hdr_0 : gcrc_h0;
                tx_h1 <= bus.goodcrc_req ? bus.goodcrc_hdr_1 : gcrc_h1;
            end else if (take_m) begin
                tx_h0 <= msg_accept ? bus.tcpm_hdr_0 : msg_h0;
                tx_h1 <= msg_accept ? bus.tcpm_hdr_1 : msg_h1;
            end
            gdone_q <= gdone_nxt;
            succ_q  <= succ_nxt;
            fail_q  <= fail_nxt;
        end
    end

    assign bus.phy_tx_start        = tx_start;
    assign bus.phy_tx_hdr_0        = tx_h0;
    assign bus.phy_tx_hdr_1        = tx_h1;
    assign bus.goodcrc_tx_complete = gdone_q;
    assign bus.tcpm_tx_success     = succ_q;
    assign bus.tcpm_tx_failed      = fail_q;
    assign bus.tx_busy             = (state != IDLE) || gcrc_pend || msg_pend;
    assign fsm_state               = state;

endmodule
